// File: rtl/bus_grant_sched.sv
// bus_grant_sched -- round-robin bus arbiter with registered one-hot grant.
//
// Sources request the bus through req[31:0]. From IDLE, the first requester
// at or above the rotating pointer wins. The pointer search wraps from 31
// to 0. The winner is granted one cycle later and keeps the bus until it
// drops its request. Every grant is followed by one RELEASE cycle for bus
// turnaround, and then the arbiter returns to IDLE before it re-arbitrates.
//
// Optional feature: define BUS_SCHED_TIMEOUT_EN to force-release an owner
// after MAX_HOLD granted cycles. A forced release pulses tmo for one cycle.
// In the default build (macro undefined) there is no hold counter and tmo
// is tied low.
//
// Ports:
//   clk  in   1  rising-edge clock
//   clr  in   1  asynchronous active-low reset
//   req  in  32  per-source request, bit i = source i
//   gnt  out 32  registered one-hot grant
//   sel  out  5  registered binary index of current/last owner (mux select)
//   busy out  1  high in GRANT or RELEASE
//   tmo  out  1  one-cycle pulse on timeout release
module bus_grant_sched #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] req,
  output logic [31:0] gnt,
  output logic [4:0]  sel,
  output logic        busy,
  output logic        tmo
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("bus_grant_sched: MAX_HOLD must be in 2..255");
  end

  state_t      state, state_next;
  logic [31:0] gnt_next;
  logic [4:0]  sel_next;
  logic [4:0]  ptr, ptr_next;
  logic [4:0]  winner;
  logic [4:0]  idx;
  logic        found;
  logic        timeout;

  // The priority search starts at ptr and walks upward. The 5-bit index
  // wraps from 31 back to 0 on its own, so no modulo logic is needed.
  always_comb begin
    found  = 1'b0;
    winner = ptr;
    idx    = ptr;
    for (int i = 0; i < 32; i++) begin
      idx = ptr + 5'(i);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

`ifdef BUS_SCHED_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] hold;

  assign timeout = (hold == HOLD_LAST);

  // hold counts the cycles spent in GRANT. It is 0 on the first granted
  // cycle, so the owner holds the bus for exactly MAX_HOLD cycles.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      hold <= '0;
    end else if (state == GRANT && state_next == GRANT) begin
      hold <= hold + 8'd1;
    end else begin
      hold <= '0;
    end
  end

  // The pulse is raised only when the owner is still requesting. If the
  // request drops in the timeout cycle, that is an ordinary release.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      tmo <= 1'b0;
    end else begin
      tmo <= (state == GRANT) && req[sel] && timeout;
    end
  end
`else
  assign timeout = 1'b0;
  assign tmo     = 1'b0;
`endif

  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    gnt_next   = gnt;
    sel_next   = sel;
    ptr_next   = ptr;
    case (state)
      IDLE: begin
        gnt_next = '0;
        if (found) begin
          state_next = GRANT;
          gnt_next   = 32'd1 << winner;
          sel_next   = winner;
          ptr_next   = winner + 5'd1;
        end
      end
      GRANT: begin
        // Only the owner's request line matters here. Other sources wait
        // for the next IDLE arbitration.
        if (!req[sel] || timeout) begin
          state_next = RELEASE;
          gnt_next   = '0;
        end
      end
      RELEASE: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments. All flops then
  // update together from values sampled before the edge.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
      gnt   <= '0;
      sel   <= '0;
      ptr   <= '0;
    end else begin
      state <= state_next;
      gnt   <= gnt_next;
      sel   <= sel_next;
      ptr   <= ptr_next;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_bus_grant_sched.sv
// Self-checking bench for bus_grant_sched.
// Each step drives req on the falling edge and pushes the expected
// post-edge outputs onto a scoreboard queue. It then pops and compares
// those outputs 1 ns after the next rising edge.
module tb_bus_grant_sched;

  logic        clk;
  logic        clr;
  logic [31:0] req;
  logic [31:0] gnt;
  logic [4:0]  sel;
  logic        busy;
  logic        tmo;

  typedef struct {
    logic [31:0] gnt;
    logic [4:0]  sel;
    logic        busy;
    logic        tmo;
  } exp_t;

  typedef struct {
    logic [31:0] req;
    exp_t        exp;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  bus_grant_sched #(.MAX_HOLD(4)) dut (
    .clk  (clk),
    .clr  (clr),
    .req  (req),
    .gnt  (gnt),
    .sel  (sel),
    .busy (busy),
    .tmo  (tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic step(input string name, input logic [31:0] r, input logic [31:0] eg,
                      input logic [4:0] es, input logic eb, input logic et);
    exp_t e;
    @(negedge clk);
    req = r;
    sb.push_back('{gnt: eg, sel: es, busy: eb, tmo: et});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({name, ".gnt"},  gnt,          e.gnt);
    check({name, ".sel"},  32'(sel),     32'(e.sel));
    check({name, ".busy"}, 32'(busy),    32'(e.busy));
    check({name, ".tmo"},  32'(tmo),     32'(e.tmo));
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    req = '0;
    clr = 1'b0;
    #1;
    check({name, ".rst_gnt"},  gnt,       32'h0);
    check({name, ".rst_sel"},  32'(sel),  32'h0);
    check({name, ".rst_busy"}, 32'(busy), 32'h0);
    check({name, ".rst_tmo"},  32'(tmo),  32'h0);
    @(negedge clk);
    clr = 1'b1;
  endtask

  function automatic void add(input logic [31:0] r, input logic [31:0] g,
                              input logic [4:0] s, input logic b);
    vecs.push_back('{req: r, exp: '{gnt: g, sel: s, busy: b, tmo: 1'b0}});
  endfunction

  initial begin
    clr = 1'b0;
    req = '0;
    repeat (2) @(negedge clk);
    do_reset("init");

    // Single-cycle request from source 0, then a check that ptr moved to 1.
    step("r029_grant", 32'h1, 32'h1, 5'd0, 1'b1, 1'b0);
    step("r029_rel",   32'h0, 32'h0, 5'd0, 1'b1, 1'b0);
    step("r029_idle",  32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    step("r029_ptr",   32'h3, 32'h2, 5'd1, 1'b1, 1'b0);
    step("r029_rel2",  32'h0, 32'h0, 5'd1, 1'b1, 1'b0);
    step("r029_idle2", 32'h0, 32'h0, 5'd1, 1'b0, 1'b0);

    // Sources 0 and 31 alternate, each holding for 3 cycles.
    // Each grant is followed by two cycles with gnt = 0.
    do_reset("r030");
    for (int rep = 0; rep < 2; rep++) begin
      add(32'h8000_0001, 32'h0000_0001, 5'd0,  1'b1);
      add(32'h8000_0001, 32'h0000_0001, 5'd0,  1'b1);
      add(32'h8000_0001, 32'h0000_0001, 5'd0,  1'b1);
      add(32'h8000_0000, 32'h0,         5'd0,  1'b1);
      add(32'h8000_0001, 32'h0,         5'd0,  1'b0);
      add(32'h8000_0001, 32'h8000_0000, 5'd31, 1'b1);
      add(32'h8000_0001, 32'h8000_0000, 5'd31, 1'b1);
      add(32'h8000_0001, 32'h8000_0000, 5'd31, 1'b1);
      add(32'h0000_0001, 32'h0,         5'd31, 1'b1);
      add(32'h8000_0001, 32'h0,         5'd31, 1'b0);
    end
    foreach (vecs[i])
      step($sformatf("r030[%0d]", i), vecs[i].req, vecs[i].exp.gnt,
           vecs[i].exp.sel, vecs[i].exp.busy, vecs[i].exp.tmo);

    // All sources request, and each owner releases after one cycle.
    // The grants must rotate 0..31 and then wrap back to 0.
    do_reset("r031");
    for (int k = 0; k <= 32; k++) begin
      logic [4:0]  s;
      logic [31:0] onehot;
      s      = 5'(k % 32);
      onehot = 32'd1 << s;
      step($sformatf("r031_g%0d", k), 32'hFFFF_FFFF, onehot, s, 1'b1, 1'b0);
      step($sformatf("r031_r%0d", k), ~onehot,       32'h0,  s, 1'b1, 1'b0);
      step($sformatf("r031_i%0d", k), 32'hFFFF_FFFF, 32'h0,  s, 1'b0, 1'b0);
    end

    // Reset asserted mid-GRANT must clear outputs before the next clock edge.
    do_reset("r033");
    step("r033_g", 32'h80, 32'h80, 5'd7, 1'b1, 1'b0);
    step("r033_h", 32'h80, 32'h80, 5'd7, 1'b1, 1'b0);
    @(negedge clk);
    #2;
    clr = 1'b0;
    #1;
    check("r033_async_gnt",  gnt,       32'h0);
    check("r033_async_sel",  32'(sel),  32'h0);
    check("r033_async_busy", 32'(busy), 32'h0);
    @(negedge clk);
    clr = 1'b1;
    step("r033_regrant", 32'h80, 32'h80, 5'd7, 1'b1, 1'b0);

    // A source-3 pulse during source 12's grant is ignored. A request seen
    // only in RELEASE is never granted, and sel holds while IDLE.
    do_reset("r034");
    step("r034_g",  32'h1000,          32'h1000, 5'd12, 1'b1, 1'b0);
    step("r034_p",  32'h1000 | 32'h8,  32'h1000, 5'd12, 1'b1, 1'b0);
    step("r034_h",  32'h1000,          32'h1000, 5'd12, 1'b1, 1'b0);
    step("r034_r",  32'h0,             32'h0,    5'd12, 1'b1, 1'b0);
    step("r034_rp", 32'h8,             32'h0,    5'd12, 1'b0, 1'b0);
    step("r034_i1", 32'h0,             32'h0,    5'd12, 1'b0, 1'b0);
    step("r034_i2", 32'h0,             32'h0,    5'd12, 1'b0, 1'b0);

`ifdef BUS_SCHED_TIMEOUT_EN
    // With MAX_HOLD = 4, source 5 is timed out after 4 cycles and then
    // source 9 is granted.
    do_reset("r032");
    for (int c = 0; c < 4; c++)
      step($sformatf("r032_h%0d", c), 32'h220, 32'h20, 5'd5, 1'b1, 1'b0);
    step("r032_tmo",  32'h220, 32'h0,   5'd5, 1'b1, 1'b1);
    step("r032_idle", 32'h220, 32'h0,   5'd5, 1'b0, 1'b0);
    step("r032_next", 32'h220, 32'h200, 5'd9, 1'b1, 1'b0);

    // The owner drops its request in the timeout cycle, which is a normal release.
    do_reset("r027");
    for (int c = 0; c < 4; c++)
      step($sformatf("r027_h%0d", c), 32'h20, 32'h20, 5'd5, 1'b1, 1'b0);
    step("r027_rel",  32'h0, 32'h0, 5'd5, 1'b1, 1'b0);
    step("r027_idle", 32'h0, 32'h0, 5'd5, 1'b0, 1'b0);
`else
    // Without the timeout, the grant is held well past MAX_HOLD cycles.
    do_reset("r028");
    for (int c = 0; c < 8; c++)
      step($sformatf("r028_h%0d", c), 32'h220, 32'h20, 5'd5, 1'b1, 1'b0);
    step("r028_rel",  32'h200, 32'h0,   5'd5, 1'b1, 1'b0);
    step("r028_idle", 32'h200, 32'h0,   5'd5, 1'b0, 1'b0);
    step("r028_next", 32'h200, 32'h200, 5'd9, 1'b1, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
